// File: rtl/fifo_pkt_wrapper_infill.sv
// rtl/fifo_pkt_wrapper_infill.sv - Avalon-ST packet FIFO with occupancy CSR
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   csr_*                 register port; address 0 reads fill, others read 0,
//                         writes ignored, read data registered
//   in_*                  Avalon-ST sink (data, valid/ready, sop/eop/empty)
//   out_*                 Avalon-ST source, show-ahead head beat
module fifo_pkt_wrapper_infill #(
    parameter int SYMBOLS_PER_BEAT = 64,
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int FIFO_DEPTH       = 512,
    parameter int USE_PACKETS      = 1,
    localparam int DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    csr_address,
    input  logic          csr_read,
    input  logic          csr_write,
    output logic [31:0]   csr_readdata,
    input  logic [31:0]   csr_writedata,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_startofpacket,
    input  logic          in_endofpacket,
    input  logic [5:0]    in_empty,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_startofpacket,
    output logic          out_endofpacket,
    output logic [5:0]    out_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [DW-1:0] mem_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d, mem_cnt;
    logic          in_ready_q, out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q;
    logic [31:0]   csr_readdata_q;
    logic          push, pop, load;

    // Writes have no effect, so the write side of the CSR port is sunk here.
    logic csr_unused;
    assign csr_unused = ^{csr_write, csr_writedata};

    always_comb begin
        push        = in_valid && in_ready_q;
        pop         = out_valid_q && out_ready;
        // fill includes the beat held in the output stage; the rest is in memory.
        mem_cnt     = fill_q - CW'(out_valid_q);
        // Refill the output stage whenever it is empty or being drained and
        // memory holds a beat written on an earlier edge.
        load        = (mem_cnt != '0) && (!out_valid_q || pop);
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
        out_valid_d = load || (out_valid_q && !pop);
        fill_d      = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + CW'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            csr_readdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            in_ready_q  <= (fill_d != FULL);
            out_valid_q <= out_valid_d;
            if (csr_read) begin
                csr_readdata_q <= (csr_address == 3'd0) ? 32'(fill_q) : 32'd0;
            end
        end
    end

    // Storage and output data carry no reset; out_valid qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= in_data;
        end
        if (load) begin
            out_data_q <= mem_data[rd_ptr_q];
        end
    end

    generate
        if (USE_PACKETS != 0) begin : g_pkt
            logic [7:0] mem_sb [FIFO_DEPTH];
            logic [7:0] out_sb_q;

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_sb[wr_ptr_q] <= {in_startofpacket, in_endofpacket, in_empty};
                end
                if (load) begin
                    out_sb_q <= mem_sb[rd_ptr_q];
                end
            end

            assign out_startofpacket = out_sb_q[7];
            assign out_endofpacket   = out_sb_q[6];
            assign out_empty         = out_sb_q[5:0];
        end else begin : g_nopkt
            logic pkt_unused;
            assign pkt_unused        = ^{in_startofpacket, in_endofpacket, in_empty};
            assign out_startofpacket = 1'b0;
            assign out_endofpacket   = 1'b0;
            assign out_empty         = 6'd0;
        end
    endgenerate

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign csr_readdata = csr_readdata_q;

endmodule

// File: tb/tb_fifo_pkt_wrapper_infill.sv
// tb/tb_fifo_pkt_wrapper_infill.sv - self-checking bench for fifo_pkt_wrapper_infill
module tb_fifo_pkt_wrapper_infill;

    localparam int DW    = 512;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [2:0]    csr_address;
    logic          csr_read, csr_write;
    logic [31:0]   csr_readdata, csr_writedata;
    logic [DW-1:0] in_data, out_data;
    logic          in_valid, in_ready, in_sop, in_eop;
    logic [5:0]    in_empty, out_empty;
    logic          out_valid, out_ready, out_sop, out_eop;

    fifo_pkt_wrapper_infill u_dut (
        .clk(clk), .reset_n(reset_n),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_readdata(csr_readdata), .csr_writedata(csr_writedata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty)
    );

    // Small build without packet sideband.
    logic [2:0]  p_csr_address;
    logic        p_csr_read, p_csr_write;
    logic [31:0] p_csr_readdata, p_csr_writedata;
    logic [7:0]  p_in_data, p_out_data;
    logic        p_in_valid, p_in_ready, p_in_sop, p_in_eop;
    logic [5:0]  p_in_empty, p_out_empty;
    logic        p_out_valid, p_out_ready, p_out_sop, p_out_eop;

    fifo_pkt_wrapper_infill #(
        .SYMBOLS_PER_BEAT(1), .BITS_PER_SYMBOL(8), .FIFO_DEPTH(4), .USE_PACKETS(0)
    ) u_nopkt (
        .clk(clk), .reset_n(reset_n),
        .csr_address(p_csr_address), .csr_read(p_csr_read), .csr_write(p_csr_write),
        .csr_readdata(p_csr_readdata), .csr_writedata(p_csr_writedata),
        .in_data(p_in_data), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_startofpacket(p_in_sop), .in_endofpacket(p_in_eop), .in_empty(p_in_empty),
        .out_data(p_out_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_startofpacket(p_out_sop), .out_endofpacket(p_out_eop), .out_empty(p_out_empty)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: a queue of accepted beats. A beat becomes visible on the edge
    // after it was accepted (and once it reaches the head); occupancy is the
    // queue length; ready reflects occupancy after the latest edge.
    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [5:0]    emp;
        int            pcyc;
    } beat_t;

    beat_t       mq[$];
    int          cyc = 0;
    bit          m_ready = 1'b0;
    logic [31:0] m_csr = '0;
    int          pushed_n = 0;

    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].pcyc < cyc);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ready = 1'b0;
            m_csr   = '0;
        end else begin
            automatic bit pop  = m_valid() && out_ready;
            automatic bit push = in_valid && m_ready;
            automatic int sz   = mq.size();
            cyc++;
            if (csr_read) m_csr = (csr_address == 3'd0) ? 32'(sz) : 32'd0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{in_data, in_sop, in_eop, in_empty, cyc});
                pushed_n++;
            end
            m_ready = (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        automatic bit ev = m_valid();
        chk("out_valid", DW'(out_valid), DW'(ev));
        chk("in_ready", DW'(in_ready), DW'(m_ready));
        chk("csr_readdata", DW'(csr_readdata), DW'(m_csr));
        if (ev) begin
            chk("out_data", out_data, mq[0].d);
            chk("out_sop", DW'(out_sop), DW'(mq[0].sop));
            chk("out_eop", DW'(out_eop), DW'(mq[0].eop));
            chk("out_empty", DW'(out_empty), DW'(mq[0].emp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 2000 && mq.size() > 0; k++) tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("drain_empty", DW'(out_valid), DW'(0));
    endtask

    initial begin
        reset_n = 1'b0; csr_address = 3'd0; csr_read = 1'b1; csr_write = 1'b0;
        csr_writedata = '0; in_data = '0; in_valid = 1'b0; in_sop = 1'b0;
        in_eop = 1'b0; in_empty = '0; out_ready = 1'b0;
        p_csr_address = '0; p_csr_read = 1'b0; p_csr_write = 1'b0; p_csr_writedata = '0;
        p_in_data = '0; p_in_valid = 1'b0; p_in_sop = 1'b0; p_in_eop = 1'b0;
        p_in_empty = '0; p_out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", DW'(in_ready), DW'(0));
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_in_ready", DW'(in_ready), DW'(1));

        // Single beat: push at edge N, visible after edge N+1.
        in_valid = 1'b1; in_data = {64{8'hA5}}; in_sop = 1'b1; in_eop = 1'b1; in_empty = 6'd5;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_not_yet", DW'(out_valid), DW'(0));
        tick();
        @(negedge clk);
        chk("single_valid", DW'(out_valid), DW'(1));
        chk("single_data", out_data, {64{8'hA5}});
        chk("single_sb", DW'({out_sop, out_eop, out_empty}), DW'({1'b1, 1'b1, 6'd5}));
        chk("single_csr", DW'(csr_readdata), DW'(1));
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("single_popped", DW'(out_valid), DW'(0));
        tick();
        @(negedge clk);
        chk("single_csr_zero", DW'(csr_readdata), DW'(0));

        // Fill to full, drop the extra beat, then drain in order.
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = DW'(i); in_sop = (i % 16 == 0); in_eop = (i % 16 == 15); in_empty = 6'(i % 64);
            tick();
        end
        @(negedge clk);
        chk("full_in_ready", DW'(in_ready), DW'(0));
        tick();
        in_data = DW'(512);
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("full_csr", DW'(csr_readdata), DW'(512));
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("full_drain_data", out_data, DW'(i));
            chk("full_drain_sb", DW'({out_sop, out_eop, out_empty}),
                DW'({(i % 16 == 0), (i % 16 == 15), 6'(i % 64)}));
            tick();
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("full_dropped_beat", DW'(out_valid), DW'(0));

        // Steady simultaneous push and pop at fill 3.
        tick();
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = DW'(1000 + k); in_sop = 1'b0; in_eop = 1'b0; in_empty = 6'd1;
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_data = DW'(2000 + k);
            tick();
            @(negedge clk);
            chk("steady_fill", DW'(csr_readdata), DW'(3));
        end
        tick();
        in_valid = 1'b0;
        drain();

        // CSR: other addresses read 0, writes have no effect, reads hold.
        tick();
        in_valid = 1'b1; in_data = DW'(77);
        tick(); tick();
        in_valid = 1'b0; csr_address = 3'd3;
        tick();
        @(negedge clk);
        chk("csr_addr3", DW'(csr_readdata), DW'(0));
        tick();
        csr_read = 1'b0; csr_write = 1'b1; csr_address = 3'd0; csr_writedata = 32'hFFFF_FFFF;
        tick();
        csr_write = 1'b0;
        @(negedge clk);
        chk("csr_hold", DW'(csr_readdata), DW'(0));
        tick();
        csr_read = 1'b1;
        tick();
        @(negedge clk);
        chk("csr_after_write", DW'(csr_readdata), DW'(2));
        tick();
        drain();

        // Random stream of 2000 beats.
        begin
            automatic int base = pushed_n;
            automatic int n = 0;
            tick();
            while ((pushed_n - base) < 2000 && n < 20000) begin
                in_valid = 1'($urandom_range(1));
                out_ready = 1'($urandom_range(1));
                for (int w = 0; w < DW / 32; w++) in_data[w*32 +: 32] = $urandom();
                in_sop = 1'($urandom_range(1)); in_eop = 1'($urandom_range(1));
                in_empty = 6'($urandom_range(63));
                tick();
                n++;
            end
            in_valid = 1'b0;
            chk("random_done", DW'((pushed_n - base) >= 2000), DW'(1));
            drain();
        end

        // Sideband-free build: sideband outputs stay 0, data passes.
        tick();
        p_in_valid = 1'b1; p_in_data = 8'h3C; p_in_sop = 1'b1; p_in_eop = 1'b1; p_in_empty = 6'h3F;
        tick();
        p_in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("nopkt_valid", DW'(p_out_valid), DW'(1));
        chk("nopkt_data", DW'(p_out_data), DW'(8'h3C));
        chk("nopkt_sb", DW'({p_out_sop, p_out_eop, p_out_empty}), DW'(0));
        tick();
        p_out_ready = 1'b1;
        tick();
        p_out_ready = 1'b0;
        @(negedge clk);
        chk("nopkt_popped", DW'(p_out_valid), DW'(0));

        // Reset mid-stream with 10 beats stored.
        tick();
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = DW'(300 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", DW'(out_valid), DW'(0));
        chk("midrst_in_ready", DW'(in_ready), DW'(0));
        chk("midrst_csr", DW'(csr_readdata), DW'(0));
        tick(); tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_rel_ready", DW'(in_ready), DW'(1));
        chk("midrst_rel_csr", DW'(csr_readdata), DW'(0));
        chk("midrst_rel_valid", DW'(out_valid), DW'(0));
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_wrapper_infill.md
Name: fifo_pkt_wrapper_infill

Overview:
Single-clock Avalon-ST packet FIFO with a small CSR port that reports current occupancy. It buffers full-width data beats together with packet sideband (startofpacket, endofpacket, empty). It is used as the storage element behind the pipeline's packet FIFO wrappers, which read occupancy via CSR address 0 for almost-full backpressure. Output is show-ahead: the head entry is presented whenever out_valid is high.

Parameters:
SYMBOLS_PER_BEAT, 64, symbols per data beat
BITS_PER_SYMBOL, 8, bits per symbol; data width DW = SYMBOLS_PER_BEAT*BITS_PER_SYMBOL
FIFO_DEPTH, 512, number of beat entries; must be a power of 2 and at least 4
USE_PACKETS, 1, 1 = store and forward sop/eop/empty; 0 = drive out_startofpacket, out_endofpacket and out_empty to 0

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
csr_address  in  3  CSR register select
csr_read  in  1  CSR read strobe
csr_write  in  1  CSR write strobe; writes have no effect
csr_readdata  out  32  CSR read data
csr_writedata  in  32  ignored
in_data  in  DW  input beat
in_valid  in  1  input beat valid
in_ready  out  1  FIFO can accept a beat
in_startofpacket  in  1  first beat of packet
in_endofpacket  in  1  last beat of packet
in_empty  in  6  empty symbols in the last beat
out_data  out  DW  head beat
out_valid  out  1  head beat valid
out_ready  in  1  downstream accepts head beat
out_startofpacket  out  1  head sop
out_endofpacket  out  1  head eop
out_empty  out  6  head empty

Behaviour:
- Reset (reset_n=0, async):
  - clears the read/write pointers and the occupancy counter;
  - out_valid=0, in_ready=0, csr_readdata=0.
  - Memory contents are not cleared.
  - in_ready rises on the first clk edge after reset_n deasserts.
  - Reset mid-operation discards all stored beats.
- Push:
  - occurs when in_valid && in_ready.
  - Stores {in_data, in_startofpacket, in_endofpacket, in_empty} at the write pointer and increments the pointer.
  - Pointer wrap-around is modulo FIFO_DEPTH.
- in_ready = (fill < FIFO_DEPTH), registered.
  - It drops the cycle after the push that makes fill = FIFO_DEPTH.
  - in_valid while in_ready=0 is ignored; the beat is not stored.
- Pop:
  - occurs when out_valid && out_ready.
  - Advances the head to the next entry.
  - out_ready while out_valid=0 is ignored.
- Latency:
  - A beat pushed into an empty FIFO at edge N is presented with out_valid=1 after edge N+1 (one-cycle write-to-read latency).
  - Back-to-back streaming sustains one beat per cycle in both directions.
- out_* fields are meaningful only when out_valid=1.
  - They must remain stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO. Sideband fields always travel with their beat; no packet reassembly or checking is done.
- fill (occupancy):
  - width clog2(FIFO_DEPTH)+1, range 0..FIFO_DEPTH;
  - counts all accepted, not-yet-popped beats, including the beat in the output stage;
  - +1 on push, -1 on pop, unchanged on a simultaneous push and pop.
  - Simultaneous push and pop when full is impossible, because in_ready=0.
  - Simultaneous push and pop when empty: the pop does not occur (out_valid=0) and fill becomes 1.
- CSR:
  - Reads are registered. When csr_read=1 at an edge, csr_readdata takes the value of the addressed register, sampled before that edge's updates.
  - When csr_read=0, csr_readdata holds its value.
  - Address 0: fill, zero-extended to 32 bits.
  - All other addresses read 0. Writes are ignored.
  - With csr_read tied to 1, csr_readdata tracks fill with one cycle of lag.
- USE_PACKETS=0: sideband bits are not stored; out_startofpacket=0, out_endofpacket=0, out_empty=0.

Test Plan:
1. Reset: assert reset_n=0 mid-stream with 10 beats stored -> immediately out_valid=0 and in_ready=0; after release, in_ready=1, fill=0 and csr_readdata (csr_read=1, address 0) reads 0.
2. Single beat: push data=0xA5..A5, sop=1, eop=1, empty=5 at edge N -> out_valid=1 after edge N+1 with identical fields; csr_readdata reads 1; pop it -> out_valid=0 and csr_readdata returns to 0.
3. Fill to full: push 512 incrementing beats with out_ready=0 -> in_ready=0 after the 512th push; a 513th push is dropped; csr_readdata reads 512; drain all -> values 0..511 in order, sideband intact.
4. Simultaneous push and pop: at steady fill=3, assert in_valid and out_ready for 100 cycles -> fill stays 3 and output order is preserved.
5. Wrap-around: stream 2000 beats with random in_valid/out_ready (about 50% each) -> output sequence equals input sequence; fill always within 0..512; out_* stable while stalled.
6. CSR: read address 3 -> csr_readdata=0; csr_write to address 0 -> fill is unaffected; USE_PACKETS=0 build -> out_startofpacket, out_endofpacket and out_empty are always 0.
